// File: rtl/islem_sirali_pkg.sv
// Shared constants for the operand sequencer: ALU op codes, FSM state
// encoding and the default data width.
package islem_sirali_pkg;

  localparam int VERI_W_DEF = 8;

  localparam logic [2:0] TOPLA       = 3'b000;
  localparam logic [2:0] CIKAR       = 3'b001;
  localparam logic [2:0] ARTIR       = 3'b010;
  localparam logic [2:0] KARE        = 3'b011;
  localparam logic [2:0] KARSILASTIR = 3'b100;

  localparam logic [1:0] BOSTA = 2'd0;
  localparam logic [1:0] OKU   = 2'd1;
  localparam logic [1:0] YAZ   = 2'd2;

  // Legal ALU op codes are 000..100; 101..111 are flagged as illegal.
  function automatic logic gecerli_islem(input logic [2:0] islem);
    return islem <= KARSILASTIR;
  endfunction

endpackage

// File: rtl/islem_sirali_yazmac_dosyasi.sv
// REG_SAYISI x VERI_W register file: one synchronous write port, two read
// ports sampled by the sequencer on accept, and a combinational debug port.
module islem_sirali_yazmac_dosyasi #(
  parameter int VERI_W     = 8,
  parameter int REG_SAYISI = 4,
  parameter int ADR_W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              yaz_en_in,
  input  logic [ADR_W-1:0]  yaz_adr_in,
  input  logic [VERI_W-1:0] yaz_veri_in,
  input  logic [ADR_W-1:0]  oku1_adr_in,
  output logic [VERI_W-1:0] oku1_veri_out,
  input  logic [ADR_W-1:0]  oku2_adr_in,
  output logic [VERI_W-1:0] oku2_veri_out,
  input  logic [ADR_W-1:0]  dbg_adr_in,
  output logic [VERI_W-1:0] dbg_veri_out
);

  logic [VERI_W-1:0] yazmac_q [REG_SAYISI];
  logic [VERI_W-1:0] yazmac_d [REG_SAYISI];

  always_comb begin
    yazmac_d = yazmac_q;
    if (yaz_en_in) yazmac_d[yaz_adr_in] = yaz_veri_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_SAYISI; i++) yazmac_q[i] <= '0;
    end else begin
      yazmac_q <= yazmac_d;
    end
  end

  assign oku1_veri_out = yazmac_q[oku1_adr_in];
  assign oku2_veri_out = yazmac_q[oku2_adr_in];
  assign dbg_veri_out  = yazmac_q[dbg_adr_in];

endmodule

// File: rtl/islem_sirali.sv
// Operand sequencer: accepts one instruction per 3 cycles, presents registered
// operands to the ALU, and writes the ALU result back to the destination.
module islem_sirali
  import islem_sirali_pkg::*;
#(
  parameter int VERI_W     = VERI_W_DEF,
  parameter int REG_SAYISI = 4,
  parameter int ADR_W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              komut_gecerli_in,
  output logic              komut_hazir_out,
  input  logic [2:0]        komut_islem_in,
  input  logic [ADR_W-1:0]  komut_hedef_in,
  input  logic [ADR_W-1:0]  komut_k1_in,
  input  logic [ADR_W-1:0]  komut_k2_in,
  input  logic              yukle_in,
  input  logic [ADR_W-1:0]  yukle_adr_in,
  input  logic [VERI_W-1:0] yukle_veri_in,
  output logic [2:0]        alu_islem_out,
  output logic [VERI_W-1:0] alu_s1_out,
  output logic [VERI_W-1:0] alu_s2_out,
  input  logic [VERI_W-1:0] alu_s_in,
  output logic              bitti_out,
  output logic              hata_out,
  input  logic [ADR_W-1:0]  okuma_adr_in,
  output logic [VERI_W-1:0] okuma_veri_out
);

  // Handshake: an instruction transfers at a rising edge where
  // komut_gecerli_in && komut_hazir_out; a load strobe in BOSTA wins and
  // holds ready low for that cycle.

  logic [1:0]        durum_q, durum_d;
  logic [2:0]        alu_islem_q, alu_islem_d;
  logic [VERI_W-1:0] alu_s1_q, alu_s1_d;
  logic [VERI_W-1:0] alu_s2_q, alu_s2_d;
  logic [ADR_W-1:0]  hedef_q, hedef_d;
  logic              bitti_q, bitti_d;
  logic              hata_q, hata_d;

  logic              yaz_en;
  logic [ADR_W-1:0]  yaz_adr;
  logic [VERI_W-1:0] yaz_veri;
  logic [VERI_W-1:0] oku1_veri, oku2_veri;

  islem_sirali_yazmac_dosyasi #(
    .VERI_W    (VERI_W),
    .REG_SAYISI(REG_SAYISI),
    .ADR_W     (ADR_W)
  ) u_yazmac (
    .clk          (clk),
    .rst          (rst),
    .yaz_en_in    (yaz_en),
    .yaz_adr_in   (yaz_adr),
    .yaz_veri_in  (yaz_veri),
    .oku1_adr_in  (komut_k1_in),
    .oku1_veri_out(oku1_veri),
    .oku2_adr_in  (komut_k2_in),
    .oku2_veri_out(oku2_veri),
    .dbg_adr_in   (okuma_adr_in),
    .dbg_veri_out (okuma_veri_out)
  );

  assign komut_hazir_out = (durum_q == BOSTA) && !yukle_in;

  always_comb begin
    durum_d     = durum_q;
    alu_islem_d = alu_islem_q;
    alu_s1_d    = alu_s1_q;
    alu_s2_d    = alu_s2_q;
    hedef_d     = hedef_q;
    bitti_d     = 1'b0;
    hata_d      = 1'b0;
    yaz_en      = 1'b0;
    yaz_adr     = yukle_adr_in;
    yaz_veri    = yukle_veri_in;
    case (durum_q)
      BOSTA: begin
        if (yukle_in) begin
          yaz_en = 1'b1;
        end else if (komut_gecerli_in) begin
          alu_islem_d = komut_islem_in;
          alu_s1_d    = oku1_veri;
          alu_s2_d    = oku2_veri;
          hedef_d     = komut_hedef_in;
          durum_d     = OKU;
        end
      end
      OKU: durum_d = YAZ;
      YAZ: begin
        // alu_islem_q still holds the accepted op; it only changes on accept.
        bitti_d = 1'b1;
        if (gecerli_islem(alu_islem_q)) begin
          yaz_en   = 1'b1;
          yaz_adr  = hedef_q;
          yaz_veri = alu_s_in;
        end else begin
          hata_d = 1'b1;
        end
        durum_d = BOSTA;
      end
      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      durum_q     <= BOSTA;
      alu_islem_q <= '0;
      alu_s1_q    <= '0;
      alu_s2_q    <= '0;
      hedef_q     <= '0;
      bitti_q     <= 1'b0;
      hata_q      <= 1'b0;
    end else begin
      durum_q     <= durum_d;
      alu_islem_q <= alu_islem_d;
      alu_s1_q    <= alu_s1_d;
      alu_s2_q    <= alu_s2_d;
      hedef_q     <= hedef_d;
      bitti_q     <= bitti_d;
      hata_q      <= hata_d;
    end
  end

  assign alu_islem_out = alu_islem_q;
  assign alu_s1_out    = alu_s1_q;
  assign alu_s2_out    = alu_s2_q;
  assign bitti_out     = bitti_q;
  assign hata_out      = hata_q;

endmodule

// File: tb/tb_islem_sirali.sv
// Bench for islem_sirali: directed cases with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_islem_sirali;
  import islem_sirali_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       komut_gecerli_in = 1'b0;
  logic       komut_hazir_out;
  logic [2:0] komut_islem_in = '0;
  logic [1:0] komut_hedef_in = '0;
  logic [1:0] komut_k1_in = '0;
  logic [1:0] komut_k2_in = '0;
  logic       yukle_in = 1'b0;
  logic [1:0] yukle_adr_in = '0;
  logic [7:0] yukle_veri_in = '0;
  logic [2:0] alu_islem_out;
  logic [7:0] alu_s1_out, alu_s2_out, alu_s_in;
  logic       bitti_out, hata_out;
  logic [1:0] okuma_adr_in = '0;
  logic [7:0] okuma_veri_out;

  int gecen = 0;
  int toplam = 0;

  islem_sirali dut (
    .clk(clk), .rst(rst),
    .komut_gecerli_in(komut_gecerli_in), .komut_hazir_out(komut_hazir_out),
    .komut_islem_in(komut_islem_in), .komut_hedef_in(komut_hedef_in),
    .komut_k1_in(komut_k1_in), .komut_k2_in(komut_k2_in),
    .yukle_in(yukle_in), .yukle_adr_in(yukle_adr_in), .yukle_veri_in(yukle_veri_in),
    .alu_islem_out(alu_islem_out), .alu_s1_out(alu_s1_out), .alu_s2_out(alu_s2_out),
    .alu_s_in(alu_s_in), .bitti_out(bitti_out), .hata_out(hata_out),
    .okuma_adr_in(okuma_adr_in), .okuma_veri_out(okuma_veri_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- ALU stand-in ----------------
  function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a + 8'd1;
      3'd3: begin p = a * a; return p[7:0]; end
      3'd4: return (a > b) ? 8'd1 : 8'd0;
      default: return 8'hAA;
    endcase
  endfunction

  assign alu_s_in = alu_ref(alu_islem_out, alu_s1_out, alu_s2_out);

  // ---------------- reference model ----------------
  // Transaction view: an accepted instruction computes its result at once
  // and commits it two edges later; nothing may change the sources meanwhile.
  logic [7:0] m_reg [4];
  int         m_kalan = 0;
  logic [1:0] m_hedef;
  logic [7:0] m_sonuc;
  logic       m_gecerli_op;
  logic [2:0] m_alu_op;
  logic [7:0] m_alu_s1, m_alu_s2;
  logic       m_bitti, m_hata;
  bit         m_hazir_basladi = 0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) m_reg[i] = '0;
      m_kalan = 0; m_bitti = 0; m_hata = 0;
      m_alu_op = '0; m_alu_s1 = '0; m_alu_s2 = '0;
      m_hazir_basladi = 1;
    end else begin
      m_bitti = 0; m_hata = 0;
      if (m_kalan == 0) begin
        if (yukle_in) begin
          m_reg[yukle_adr_in] = yukle_veri_in;
        end else if (komut_gecerli_in) begin
          m_alu_op = komut_islem_in;
          m_alu_s1 = m_reg[komut_k1_in];
          m_alu_s2 = m_reg[komut_k2_in];
          m_hedef = komut_hedef_in;
          m_gecerli_op = (komut_islem_in < 3'd5);
          m_sonuc = alu_ref(komut_islem_in, m_alu_s1, m_alu_s2);
          m_kalan = 2;
        end
      end else begin
        m_kalan--;
        if (m_kalan == 0) begin
          m_bitti = 1;
          if (m_gecerli_op) m_reg[m_hedef] = m_sonuc;
          else m_hata = 1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic kontrol(input string ad, input logic [7:0] gercek, input logic [7:0] beklenen);
    toplam++;
    if (gercek === beklenen) gecen++;
    else $display("FAIL %s: got %h, expected %h at %0t", ad, gercek, beklenen, $time);
  endtask

  always @(negedge clk) begin
    if (m_hazir_basladi && !rst) begin
      kontrol("hazir", {7'd0, komut_hazir_out}, {7'd0, (m_kalan == 0) && !yukle_in});
      kontrol("bitti", {7'd0, bitti_out}, {7'd0, m_bitti});
      kontrol("hata", {7'd0, hata_out}, {7'd0, m_hata});
      kontrol("alu_islem", {5'd0, alu_islem_out}, {5'd0, m_alu_op});
      kontrol("alu_s1", alu_s1_out, m_alu_s1);
      kontrol("alu_s2", alu_s2_out, m_alu_s2);
      kontrol("okuma", okuma_veri_out, m_reg[okuma_adr_in]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tik();
    @(posedge clk); #1;
  endtask

  task automatic yukle(input logic [1:0] adr, input logic [7:0] veri);
    yukle_in = 1; yukle_adr_in = adr; yukle_veri_in = veri;
    tik();
    yukle_in = 0;
  endtask

  // Presents an instruction, waits (bounded) for ready, returns just after the accept edge.
  task automatic komut(input logic [2:0] op, input logic [1:0] h, input logic [1:0] k1, input logic [1:0] k2);
    int n = 0;
    komut_gecerli_in = 1; komut_islem_in = op; komut_hedef_in = h;
    komut_k1_in = k1; komut_k2_in = k2;
    while (!komut_hazir_out && n < 10) begin tik(); n++; end
    if (n == 10) begin
      toplam++;
      $display("FAIL komut_timeout: ready never rose, expected within 10 cycles");
    end
    tik();
    komut_gecerli_in = 0;
  endtask

  task automatic oku_kontrol(input string ad, input logic [1:0] adr, input logic [7:0] beklenen);
    okuma_adr_in = adr; #1;
    kontrol(ad, okuma_veri_out, beklenen);
  endtask

  // Runs one instruction and checks the completion pulse and destination value.
  task automatic islem(input string ad, input logic [2:0] op, input logic [1:0] h,
                       input logic [1:0] k1, input logic [1:0] k2,
                       input logic [7:0] beklenen, input logic beklenen_hata);
    komut(op, h, k1, k2);
    kontrol({ad, "_bitti_erken"}, {7'd0, bitti_out}, 8'd0);
    tik(); tik();
    kontrol({ad, "_bitti"}, {7'd0, bitti_out}, 8'd1);
    kontrol({ad, "_hata"}, {7'd0, hata_out}, {7'd0, beklenen_hata});
    oku_kontrol(ad, h, beklenen);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1; tik(); tik(); rst = 0;

    // Reset mid-OKU aborts the instruction.
    yukle(2'd1, 8'h11);
    komut(TOPLA, 2'd3, 2'd1, 2'd1);
    rst = 1; tik(); tik(); rst = 0; #1;
    kontrol("rst_hazir", {7'd0, komut_hazir_out}, 8'd1);
    kontrol("rst_alu_s1", alu_s1_out, 8'h00);
    kontrol("rst_alu_islem", {5'd0, alu_islem_out}, 8'h00);
    tik();
    kontrol("rst_bitti", {7'd0, bitti_out}, 8'd0);
    for (int i = 0; i < 4; i++) oku_kontrol("rst_reg", i[1:0], 8'h00);

    yukle(2'd0, 8'h05); yukle(2'd1, 8'h03);
    islem("topla", TOPLA, 2'd2, 2'd0, 2'd1, 8'h08, 1'b0);
    islem("bagimli", TOPLA, 2'd3, 2'd2, 2'd2, 8'h10, 1'b0);

    yukle(2'd0, 8'h03); yukle(2'd1, 8'h05);
    islem("cikar", CIKAR, 2'd3, 2'd0, 2'd1, 8'hFE, 1'b0);
    yukle(2'd0, 8'h14);
    islem("kare", KARE, 2'd3, 2'd0, 2'd0, 8'h90, 1'b0);

    yukle(2'd0, 8'h07); yukle(2'd1, 8'h07);
    islem("karsilastir_esit", KARSILASTIR, 2'd3, 2'd0, 2'd1, 8'h00, 1'b0);
    yukle(2'd0, 8'h08);
    islem("karsilastir_buyuk", KARSILASTIR, 2'd3, 2'd0, 2'd1, 8'h01, 1'b0);
    yukle(2'd1, 8'hFF);
    islem("artir", ARTIR, 2'd3, 2'd1, 2'd1, 8'h00, 1'b0);

    yukle(2'd2, 8'h55);
    islem("gecersiz", 3'b101, 2'd2, 2'd0, 2'd1, 8'h55, 1'b1);

    // Load and instruction together: load wins, instruction goes next cycle.
    tik();
    yukle_in = 1; yukle_adr_in = 2'd0; yukle_veri_in = 8'h21;
    komut_gecerli_in = 1; komut_islem_in = TOPLA; komut_hedef_in = 2'd3;
    komut_k1_in = 2'd0; komut_k2_in = 2'd0; #1;
    kontrol("oncelik_hazir", {7'd0, komut_hazir_out}, 8'd0);
    tik(); yukle_in = 0; #1;
    kontrol("oncelik_hazir_sonra", {7'd0, komut_hazir_out}, 8'd1);
    tik(); komut_gecerli_in = 0;
    kontrol("oncelik_s1", alu_s1_out, 8'h21);
    tik(); tik();
    oku_kontrol("oncelik_sonuc", 2'd3, 8'h42);

    // Randomized traffic, including loads attempted while busy.
    for (int c = 0; c < 3000; c++) begin
      rst              = ($urandom_range(0, 299) == 0);
      yukle_in         = ($urandom_range(0, 3) == 0);
      yukle_adr_in     = 2'($urandom_range(0, 3));
      yukle_veri_in    = 8'($urandom_range(0, 255));
      komut_gecerli_in = ($urandom_range(0, 1) == 1);
      komut_islem_in   = 3'($urandom_range(0, 7));
      komut_hedef_in   = 2'($urandom_range(0, 3));
      komut_k1_in      = 2'($urandom_range(0, 3));
      komut_k2_in      = 2'($urandom_range(0, 3));
      okuma_adr_in     = 2'($urandom_range(0, 3));
      tik();
    end
    rst = 0; yukle_in = 0; komut_gecerli_in = 0;
    tik(); tik();

    $display("%0d/%0d checks passed", gecen, toplam);
    $finish;
  end

endmodule
